// File: rtl/pn_pkg.sv
// CCSDS pseudo-noise keystream helpers shared by the derandomizer.
// The state holds the next 8 sequence bits, earliest bit in the MSB.
package pn_pkg;

    localparam logic [7:0] PN_SEED = 8'hFF;
    localparam logic [7:0] PN_TAPS = 8'hA9;
    localparam int LRPT_CVCDU_BYTES = 1020;

    // One recurrence step: s[n+8] = XOR of s[n+j] where taps[j] is set.
    function automatic logic [7:0] pn_step(
        input logic [7:0] state,
        input logic [7:0] taps
    );
        logic fb;
        fb = 1'b0;
        for (int j = 0; j < 8; j++) begin
            fb = fb ^ (taps[j] & state[7-j]);
        end
        return {state[6:0], fb};
    endfunction

    function automatic logic [7:0] pn_advance(
        input logic [7:0] state,
        input logic [7:0] taps,
        input int         nsteps
    );
        logic [7:0] s;
        s = state;
        for (int n = 0; n < nsteps; n++) begin
            s = pn_step(s, taps);
        end
        return s;
    endfunction

    // n keystream bytes in the low 8*n bits, earliest byte highest.
    function automatic logic [31:0] pn_bytes(
        input logic [7:0] state,
        input logic [7:0] taps,
        input int         n
    );
        logic [31:0] r;
        logic [7:0]  s;
        r = '0;
        s = state;
        for (int i = 0; i < n; i++) begin
            r = {r[23:0], s};
            s = pn_advance(s, taps, 8);
        end
        return r;
    endfunction

endpackage

// File: rtl/pn_keystream_gen.sv
// Keystream state register and one-cycle multi-byte key generation.
// load_seed keys this beat from SEED; resync parks the state at SEED.
module pn_keystream_gen
    import pn_pkg::*;
#(
    parameter int         BYTES_PER_BEAT = 1,
    parameter logic [7:0] SEED           = PN_SEED,
    parameter logic [7:0] TAPS           = PN_TAPS
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        load_seed,
    input  logic                        advance,
    input  logic                        resync,
    output logic [8*BYTES_PER_BEAT-1:0] key
);

    localparam int W = 8 * BYTES_PER_BEAT;

    logic [7:0] r_state;
    logic [7:0] w_base;
    logic [7:0] w_next;

    // Base state for this beat and the state after consuming it.
    always_comb begin
        w_base = load_seed ? SEED : r_state;
        w_next = pn_advance(w_base, TAPS, W);
    end

    for (genvar i = 0; i < BYTES_PER_BEAT; i++) begin : g_key
        assign key[W-1-8*i -: 8] = pn_advance(w_base, TAPS, 8 * i);
    end

    // State moves only on accepted beats; frame end returns to SEED.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= SEED;
        end else if (advance) begin
            r_state <= resync ? SEED : w_next;
        end
    end

endmodule

// File: rtl/pn_derandomizer.sv
// CCSDS PN derandomizer: XORs CVCDU bytes with the periodic keystream.
// Single output register stage with valid/ready backpressure.
module pn_derandomizer
    import pn_pkg::*;
#(
    parameter int         BYTES_PER_BEAT = 1,
    parameter int         FRAME_BYTES    = LRPT_CVCDU_BYTES,
    parameter logic [7:0] SEED           = PN_SEED,
    parameter logic [7:0] TAPS           = PN_TAPS
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic [8*BYTES_PER_BEAT-1:0] data_in,
    input  logic                        valid_in,
    input  logic                        sof_in,
    output logic                        ready_out,
    input  logic                        bypass_in,
    output logic [8*BYTES_PER_BEAT-1:0] data_out,
    output logic                        valid_out,
    input  logic                        ready_in,
    output logic                        sof_out,
    output logic                        eof_out,
    output logic                        frame_err
);

    localparam int W     = 8 * BYTES_PER_BEAT;
    localparam int BEATS = FRAME_BYTES / BYTES_PER_BEAT;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    logic [W-1:0]  r_data;
    logic          r_valid;
    logic          r_sof;
    logic          r_eof;
    logic          r_err;
    logic [CW-1:0] r_cnt;

    logic          w_accept;
    logic          w_start;
    logic          w_eof;
    logic [CW-1:0] w_pos;
    logic [W-1:0]  w_key;

    assign ready_out = !r_valid || ready_in;
    assign w_accept  = valid_in && ready_out;
    assign w_start   = sof_in || (r_cnt == '0);

    // Beat position in frame; a start beat always counts as beat 0.
    always_comb begin
        w_pos = w_start ? '0 : r_cnt;
        w_eof = (w_pos == LAST);
    end

    pn_keystream_gen #(
        .BYTES_PER_BEAT (BYTES_PER_BEAT),
        .SEED           (SEED),
        .TAPS           (TAPS)
    ) u_gen (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .load_seed (w_start),
        .advance   (w_accept),
        .resync    (w_eof),
        .key       (w_key)
    );

    // Beat counter wraps at frame end so the next frame self-starts.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= w_eof ? '0 : w_pos + 1'b1;
        end
    end

    // Output register; holds while downstream stalls.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_sof   <= 1'b0;
            r_eof   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_accept && sof_in && (r_cnt != '0);
            if (ready_out) begin
                r_valid <= valid_in;
                if (w_accept) begin
                    r_data <= bypass_in ? data_in : (data_in ^ w_key);
                    r_sof  <= w_start;
                    r_eof  <= w_eof;
                end
            end
        end
    end

    assign data_out  = r_data;
    assign valid_out = r_valid;
    assign sof_out   = r_sof;
    assign eof_out   = r_eof;
    assign frame_err = r_err;

endmodule

// File: tb/tb_pn_derandomizer.sv
// Scoreboard bench for pn_derandomizer across three parameter sets.
// Golden keystream is built bit-serially from h(x)=x^8+x^7+x^5+x^3+1.
module tb_pn_derandomizer;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [7:0]  d0, q0;
    logic        v0, s0, b0, r0, ro0, vo0, so0, eo0, fe0;
    logic [31:0] d1, q1;
    logic        v1, s1, b1, r1, ro1, vo1, so1, eo1, fe1;
    logic [7:0]  d2, q2;
    logic        v2, s2, b2, r2, ro2, vo2, so2, eo2, fe2;

    pn_derandomizer #(.BYTES_PER_BEAT(1), .FRAME_BYTES(1020)) u0 (
        .clk_in(clk), .rst_in(rst_n), .data_in(d0), .valid_in(v0),
        .sof_in(s0), .ready_out(ro0), .bypass_in(b0), .data_out(q0),
        .valid_out(vo0), .ready_in(r0), .sof_out(so0), .eof_out(eo0),
        .frame_err(fe0));

    pn_derandomizer #(.BYTES_PER_BEAT(4), .FRAME_BYTES(1020)) u1 (
        .clk_in(clk), .rst_in(rst_n), .data_in(d1), .valid_in(v1),
        .sof_in(s1), .ready_out(ro1), .bypass_in(b1), .data_out(q1),
        .valid_out(vo1), .ready_in(r1), .sof_out(so1), .eof_out(eo1),
        .frame_err(fe1));

    pn_derandomizer #(.BYTES_PER_BEAT(1), .FRAME_BYTES(8)) u2 (
        .clk_in(clk), .rst_in(rst_n), .data_in(d2), .valid_in(v2),
        .sof_in(s2), .ready_out(ro2), .bypass_in(b2), .data_out(q2),
        .valid_out(vo2), .ready_in(r2), .sof_out(so2), .eof_out(eo2),
        .frame_err(fe2));

    int checks = 0;
    int failures = 0;
    logic [7:0]  ks [255];
    logic [33:0] sb [$];
    logic [31:0] got [$];
    int mcnt;
    bit errp;
    int cur_bpb;
    int cur_fb;

    task automatic idle_all();
        d0 = '0; v0 = 0; s0 = 0; b0 = 0; r0 = 1;
        d1 = '0; v1 = 0; s1 = 0; b1 = 0; r1 = 1;
        d2 = '0; v2 = 0; s2 = 0; b2 = 0; r2 = 1;
    endtask

    task automatic sel(input int id);
        cur_bpb = (id == 1) ? 4 : 1;
        cur_fb  = (id == 0) ? 1020 : (id == 1) ? 255 : 8;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        idle_all();
        sb.delete();
        got.delete();
        mcnt = 0;
        errp = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic cyc(input int id, input logic [31:0] d,
                       input bit v, input bit s, input bit b, input bit r);
        logic rdy, vo, so, eo, fe, st, eof;
        logic [31:0] dout, dm, key, xd;
        logic [33:0] e;
        int pos;
        @(negedge clk);
        case (id)
            0: begin d0 = d[7:0]; v0 = v; s0 = s; b0 = b; r0 = r; end
            1: begin d1 = d; v1 = v; s1 = s; b1 = b; r1 = r; end
            default: begin d2 = d[7:0]; v2 = v; s2 = s; b2 = b; r2 = r; end
        endcase
        #1;
        case (id)
            0: begin
                rdy = ro0; vo = vo0; so = so0; eo = eo0; fe = fe0;
                dout = {24'b0, q0};
            end
            1: begin
                rdy = ro1; vo = vo1; so = so1; eo = eo1; fe = fe1;
                dout = q1;
            end
            default: begin
                rdy = ro2; vo = vo2; so = so2; eo = eo2; fe = fe2;
                dout = {24'b0, q2};
            end
        endcase
        checks++;
        if (fe !== errp) begin
            failures++;
            $display("FAIL frame_err id=%0d got=%b exp=%b", id, fe, errp);
        end
        errp = 0;
        if (vo && r) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_out id=%0d got=%h exp=none",
                         id, dout);
            end else begin
                e = sb.pop_front();
                if ({so, eo, dout} !== e) begin
                    failures++;
                    $display("FAIL sb id=%0d got=%b%b_%h exp=%b%b_%h", id,
                             so, eo, dout, e[33], e[32], e[31:0]);
                end
            end
            got.push_back(dout);
        end
        if (v && rdy) begin
            st = s || (mcnt == 0);
            if (s && mcnt != 0) errp = 1;
            if (st) mcnt = 0;
            pos = mcnt * cur_bpb;
            key = '0;
            for (int i = 0; i < cur_bpb; i++) begin
                key = {key[23:0], ks[(pos + i) % 255]};
            end
            dm = (cur_bpb == 4) ? d : {24'b0, d[7:0]};
            xd = b ? dm : (dm ^ key);
            eof = (mcnt == cur_fb - 1);
            sb.push_back({st, eof, xd});
            mcnt = eof ? 0 : mcnt + 1;
        end
    endtask

    task automatic drain(input int id, input int n);
        repeat (n) cyc(id, 0, 0, 0, 0, 1);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain id=%0d got=%0d exp=0 pending", id, sb.size());
        end
    endtask

    task automatic chk_got(input string nm, input int idx,
                           input logic [31:0] exp);
        checks++;
        if (got.size() <= idx) begin
            failures++;
            $display("FAIL %s got=missing exp=%h", nm, exp);
        end else if (got[idx] !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got[idx], exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_all();
        #12;
        checks++;
        if ({vo0, so0, eo0, fe0, q0, ro0} !== 13'b1) begin
            failures++;
            $display("FAIL reset0 got=%b exp=%b",
                     {vo0, so0, eo0, fe0, q0, ro0}, 13'b1);
        end
        checks++;
        if ({vo1, so1, eo1, fe1, q1, ro1} !== 37'b1) begin
            failures++;
            $display("FAIL reset1 got=%b exp=%b",
                     {vo1, so1, eo1, fe1, q1, ro1}, 37'b1);
        end
        checks++;
        if ({vo2, so2, eo2, fe2, q2, ro2} !== 13'b1) begin
            failures++;
            $display("FAIL reset2 got=%b exp=%b",
                     {vo2, so2, eo2, fe2, q2, ro2}, 13'b1);
        end
    endtask

    task automatic test_keystream_n1();
        logic [7:0] e8 [8];
        e8 = '{8'hFF, 8'h48, 8'h0E, 8'hC0, 8'h9A, 8'h0D, 8'h70, 8'hBC};
        do_reset();
        sel(0);
        for (int i = 0; i < 256; i++) cyc(0, 0, 1, i == 0, 0, 1);
        drain(0, 4);
        for (int i = 0; i < 8; i++) chk_got("ks_n1", i, {24'b0, e8[i]});
        chk_got("ks_period", 255, 32'hFF);
    endtask

    task automatic test_wide();
        do_reset();
        sel(1);
        for (int i = 0; i < 3; i++) cyc(1, 0, 1, i == 0, 0, 1);
        cyc(1, 32'hFFFFFFFF, 1, 1, 0, 1);
        drain(1, 4);
        chk_got("wide0", 0, 32'hFF480EC0);
        chk_got("wide1", 1, 32'h9A0D70BC);
        chk_got("wide2", 2, 32'h8E2C93AD);
        chk_got("wide_ones", 3, 32'h00B7F13F);
    endtask

    task automatic test_auto_resync();
        do_reset();
        sel(2);
        for (int i = 0; i < 16; i++) cyc(2, 0, 1, i == 0, 0, 1);
        drain(2, 4);
        chk_got("resync8", 8, 32'hFF);
        chk_got("resync9", 9, 32'h48);
    endtask

    task automatic test_sof_midframe();
        do_reset();
        sel(0);
        for (int i = 0; i < 3; i++) cyc(0, $urandom, 1, i == 0, 0, 1);
        cyc(0, 32'h5A, 1, 1, 0, 1);
        for (int i = 0; i < 4; i++) cyc(0, $urandom, 1, 0, 0, 1);
        drain(0, 4);
        chk_got("sof_mid", 3, 32'hA5);
    endtask

    task automatic test_backpressure();
        do_reset();
        sel(0);
        for (int i = 0; i < 40; i++) begin
            cyc(0, $urandom, $urandom_range(0, 1) == 1, i == 0, 0,
                !(i >= 10 && i < 15));
        end
        drain(0, 4);
    endtask

    task automatic test_bypass();
        do_reset();
        sel(1);
        for (int i = 0; i < 24; i++) begin
            cyc(1, $urandom, 1, i == 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 3) != 0);
        end
        drain(1, 4);
    endtask

    task automatic test_back_to_back();
        do_reset();
        sel(2);
        for (int i = 0; i < 24; i++) cyc(2, $urandom, 1, i % 8 == 0, 0, 1);
        drain(2, 4);
    endtask

    task automatic test_mid_reset();
        do_reset();
        sel(0);
        for (int i = 0; i < 11; i++) cyc(0, i, 1, i == 0, 0, 1);
        @(posedge clk);
        #2;
        v0 = 0;
        rst_n = 0;
        #1;
        checks++;
        if ({vo0, so0, eo0, fe0, q0} !== 12'b0) begin
            failures++;
            $display("FAIL mid_reset got=%b exp=%b",
                     {vo0, so0, eo0, fe0, q0}, 12'b0);
        end
        sb.delete();
        got.delete();
        mcnt = 0;
        errp = 0;
        @(negedge clk);
        rst_n = 1;
        cyc(0, 32'h33, 1, 0, 0, 1);
        drain(0, 4);
        chk_got("post_reset", 0, 32'hCC);
    endtask

    initial begin
        int sbit [2048];
        for (int n = 0; n < 8; n++) sbit[n] = 1;
        for (int n = 0; n + 8 < 2048; n++) begin
            sbit[n+8] = sbit[n+7] ^ sbit[n+5] ^ sbit[n+3] ^ sbit[n];
        end
        for (int k = 0; k < 255; k++) begin
            for (int j = 0; j < 8; j++) ks[k][7-j] = sbit[8*k+j][0];
        end
        mcnt = 0;
        errp = 0;
        test_reset();
        test_keystream_n1();
        test_wide();
        test_auto_resync();
        test_sof_midframe();
        test_backpressure();
        test_bypass();
        test_back_to_back();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pn_derandomizer.md
# pn_derandomizer

Parametrised CCSDS pseudo-noise derandomizer for the LRPT receive chain. It sits between frame sync (ASM stripped) and the Reed-Solomon decoder. It XORs each CVCDU byte with the 255-byte periodic keystream from h(x)=x^8+x^7+x^5+x^3+1. It processes BYTES_PER_BEAT bytes per cycle, tracks frame boundaries, applies valid/ready backpressure and supports a bypass mode.

## Interface
- BYTES_PER_BEAT, 1: bytes per beat (1, 2, 4); data width W = 8*BYTES_PER_BEAT
- FRAME_BYTES, 1020: CVCDU length in bytes; must be a multiple of BYTES_PER_BEAT
- SEED, 8'hFF: keystream state at frame start
- TAPS, 8'hA9: recurrence taps; s[n+8] = XOR of s[n+j] for every j with TAPS[j]=1
- clk_in  input  1  clock
- rst_in  input  1  asynchronous, active-low reset
- data_in  input  W  scrambled bytes; earliest byte in MSBs [W-1:W-8]
- valid_in  input  1  data_in valid
- sof_in  input  1  first beat of a CVCDU; qualified by valid_in
- ready_out  output  1  block can accept a beat
- bypass_in  input  1  pass data unchanged; sampled per accepted beat
- data_out  output  W  descrambled bytes, same byte order
- valid_out  output  1  data_out valid
- ready_in  input  1  downstream accepts
- sof_out / eof_out  output  1  first / last beat of frame, aligned with data_out
- frame_err  output  1  one-cycle pulse: sof_in arrived mid-frame

## Operation
- Keystream: bit sequence s[0..7] = SEED bits MSB first; s[n+8] per TAPS. Byte k is s[8k..8k+7], MSB first. Defaults give FF 48 0E C0 9A 0D 70 BC …, period 255 bytes.
- Keystream state: 8-bit register holding the next 8 sequence bits. Each accepted beat consumes BYTES_PER_BEAT bytes and advances the state by 8*BYTES_PER_BEAT steps, computed combinationally in one cycle.
- Accepted beat = valid_in && ready_out.
- Beat counter: 0..FRAME_BYTES/BYTES_PER_BEAT-1.
- On an accepted beat with sof_in, or with counter==0:
  - use SEED as the key for byte 0
  - set sof_out for that beat
  - counter <= 1
- On an accepted beat with counter==last:
  - set eof_out
  - counter <= 0
  - state <= SEED (auto-resync for back-to-back frames without sof_in)
- sof_in with counter!=0: frame_err pulses one cycle later, and the frame restarts from SEED with this beat. sof_in at counter==0 is not an error.
- Bypass: data_out = data_in. The keystream and counter still advance, so alignment is kept.
- After reset, counter is 0, so the first beat is treated as a frame start even without sof_in.

## Timing
- Reset values: data_out=0, valid_out=0, sof_out=0, eof_out=0, frame_err=0, state=SEED, counter=0.
- ready_out = !valid_out || ready_in. This is a single output register with no combinational path from data_in to data_out.
- Latency: accepted beat appears on data_out in the next cycle.
- Throughput: one beat per cycle while ready_in stays high.
- Stall (valid_out && !ready_in): data_out, sof_out and eof_out hold; state and counter hold.
- Reset asserted mid-frame: all outputs clear immediately (asynchronously). After release, the next beat starts a new frame.

## Structure
- Package pn_pkg:
  - constants SEED/TAPS defaults and LRPT_CVCDU_BYTES=1020
  - function pn_advance(state, nsteps) returning the next state
  - function pn_bytes(state, n) returning n keystream bytes
- Sub-module pn_keystream_gen: holds the state register, with inputs load_seed and advance and output key[W-1:0]. The top handles the handshake, counter, flags and output register.

## Test plan
- BYTES_PER_BEAT=1, zeros in, sof on first beat -> data_out FF,48,0E,C0,9A,0D,70,BC; byte 255 = FF again.
- BYTES_PER_BEAT=4, zeros in -> 0xFF480EC0, 0x9A0D70BC, 0x8E2C93AD; data_in 0xFFFFFFFF -> 0x00B7F13F.
- FRAME_BYTES=8, N=1, 16 zero bytes with no second sof -> keystream restarts FF,48… at byte 8; eof_out on bytes 7 and 15.
- sof_in on beat 3 of a frame -> frame_err one pulse; that beat's output = data_in ^ FF.
- ready_in low for 5 cycles mid-frame, with random valid_in -> no lost or duplicated bytes; output matches golden stream.
- rst_in low for 1 cycle during beat 10 -> outputs 0 immediately; next beat keyed with FF.
